rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rob_commit.sv | 130 +++++++++++++
 tb/tb_rob_commit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// Dual-issue reorder buffer: two-wide in-order allocate, two writeback ports,
// and up to two in-order commits per cycle into the register file.
module rob_commit #(
   parameter int DEPTH = 16,
   parameter int TW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          alloc_en1,
   input  logic          alloc_en2,
   input  logic [4:0]    alloc_rd1,
   input  logic [4:0]    alloc_rd2,
   input  logic          alloc_wr1,
   input  logic          alloc_wr2,
   output logic          alloc_ready,
   output logic [TW-1:0] alloc_tag1,
   output logic [TW-1:0] alloc_tag2,
   input  logic          wb_en1,
   input  logic          wb_en2,
   input  logic [TW-1:0] wb_tag1,
   input  logic [TW-1:0] wb_tag2,
   input  logic [31:0]   wb_data1,
   input  logic [31:0]   wb_data2,
   output logic [4:0]    rd1,
   output logic [4:0]    rd2,
   output logic [31:0]   rd_data1,
   output logic [31:0]   rd_data2,
   output logic          rd_en1,
   output logic          rd_en2,
   output logic [TW:0]   count,
   output logic          empty,
   output logic          full
);

   logic [DEPTH-1:0] r_valid, r_done, r_wr;
   logic [4:0]       r_rd   [DEPTH-1:0];
   logic [31:0]      r_data [DEPTH-1:0];
   logic [TW-1:0]    r_head, r_tail;
   logic [TW:0]      r_count;

   logic [TW-1:0] w_head2, w_tail2;
   logic          w_cmt1, w_cmt2;
   logic          w_alloc_ok, w_alloc1, w_alloc2;
   logic [TW:0]   w_n_alloc, w_n_cmt;

   assign w_head2 = r_head + TW'(1);
   assign w_tail2 = r_tail + TW'(1);

   // Commit sees only registered done bits, so a writeback commits one cycle later.
   assign w_cmt1 = r_valid[r_head] & r_done[r_head] & ~flush;
   assign w_cmt2 = w_cmt1 & r_valid[w_head2] & r_done[w_head2];

   assign alloc_ready = (r_count <= (TW+1)'(DEPTH-2));
   assign w_alloc_ok  = alloc_ready & ~flush;
   assign w_alloc1    = alloc_en1 & w_alloc_ok;
   assign w_alloc2    = alloc_en2 & w_alloc_ok;
   assign w_n_alloc   = (TW+1)'(w_alloc1) + (TW+1)'(w_alloc2);
   assign w_n_cmt     = (TW+1)'(w_cmt1) + (TW+1)'(w_cmt2);

   assign alloc_tag1 = r_tail;
   assign alloc_tag2 = alloc_en1 ? w_tail2 : r_tail;

   assign rd_en1   = w_cmt1 & r_wr[r_head];
   assign rd_en2   = w_cmt2 & r_wr[w_head2];
   assign rd1      = w_cmt1 ? r_rd[r_head]    : 5'd0;
   assign rd2      = w_cmt2 ? r_rd[w_head2]   : 5'd0;
   assign rd_data1 = w_cmt1 ? r_data[r_head]  : 32'd0;
   assign rd_data2 = w_cmt2 ? r_data[w_head2] : 32'd0;

   assign count = r_count;
   assign empty = (r_count == '0);
   assign full  = (r_count == (TW+1)'(DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_done  <= '0;
         r_wr    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]   <= 5'd0;
            r_data[i] <= 32'd0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_done  <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         // Port 2 is written last so it wins when both ports name the same tag.
         if (wb_en1 && r_valid[wb_tag1]) begin
            r_done[wb_tag1] <= 1'b1;
            r_data[wb_tag1] <= wb_data1;
         end
         if (wb_en2 && r_valid[wb_tag2]) begin
            r_done[wb_tag2] <= 1'b1;
            r_data[wb_tag2] <= wb_data2;
         end
         if (w_cmt1) begin
            r_valid[r_head] <= 1'b0;
            r_done[r_head]  <= 1'b0;
         end
         if (w_cmt2) begin
            r_valid[w_head2] <= 1'b0;
            r_done[w_head2]  <= 1'b0;
         end
         // alloc_ready guarantees both target slots are free, so no overlap with commit.
         if (w_alloc1) begin
            r_valid[r_tail] <= 1'b1;
            r_done[r_tail]  <= 1'b0;
            r_wr[r_tail]    <= alloc_wr1;
            r_rd[r_tail]    <= alloc_rd1;
         end
         if (w_alloc2) begin
            r_valid[alloc_tag2] <= 1'b1;
            r_done[alloc_tag2]  <= 1'b0;
            r_wr[alloc_tag2]    <= alloc_wr2;
            r_rd[alloc_tag2]    <= alloc_rd2;
         end
         r_head  <= r_head + w_n_cmt[TW-1:0];
         r_tail  <= r_tail + w_n_alloc[TW-1:0];
         r_count <= r_count + w_n_alloc - w_n_cmt;
      end
   end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed vector table, multi-cycle sequences, and a
// scoreboard of expected register-file writes checked in commit order.
module tb_rob_commit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        alloc_en1, alloc_en2, alloc_wr1, alloc_wr2;
   logic [4:0]  alloc_rd1, alloc_rd2;
   logic        alloc_ready;
   logic [3:0]  alloc_tag1, alloc_tag2;
   logic        wb_en1, wb_en2;
   logic [3:0]  wb_tag1, wb_tag2;
   logic [31:0] wb_data1, wb_data2;
   logic [4:0]  rd1, rd2;
   logic [31:0] rd_data1, rd_data2;
   logic        rd_en1, rd_en2;
   logic [4:0]  count;
   logic        empty, full;

   int n_tests = 0;
   int n_fail  = 0;

   rob_commit #(.DEPTH(16), .TW(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_en1(alloc_en1), .alloc_en2(alloc_en2),
      .alloc_rd1(alloc_rd1), .alloc_rd2(alloc_rd2),
      .alloc_wr1(alloc_wr1), .alloc_wr2(alloc_wr2),
      .alloc_ready(alloc_ready), .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2),
      .wb_en1(wb_en1), .wb_en2(wb_en2), .wb_tag1(wb_tag1), .wb_tag2(wb_tag2),
      .wb_data1(wb_data1), .wb_data2(wb_data2),
      .rd1(rd1), .rd2(rd2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .rd_en1(rd_en1), .rd_en2(rd_en2),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic        a1, a2;
      logic [4:0]  r1, r2;
      logic        w1, w2;
      logic        wb1;
      logic [3:0]  t1;
      logic [31:0] d1;
      logic        wb2;
      logic [3:0]  t2;
      logic [31:0] d2;
      logic [3:0]  etag1, etag2;
      logic [4:0]  ecnt;
      logic [1:0]  erden;
      logic [4:0]  erd1;
      logic [31:0] ed1;
   } vec_t;
   vec_t tv[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic mon(input string nm, input logic [4:0] r, input logic [31:0] d);
      sb_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s unexpected write rd=%0d data=%0h want none", nm, r, d);
      end else begin
         e = sb.pop_front();
         chk({nm, "_rd"}, 32'(r), 32'(e.rd));
         chk({nm, "_data"}, d, e.d);
      end
   endtask

   // Register-file writes are observed mid-cycle, away from the edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_en1) mon("commit1", rd1, rd_data1);
         if (rd_en2) mon("commit2", rd2, rd_data2);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      flush = 0; alloc_en1 = 0; alloc_en2 = 0; alloc_wr1 = 0; alloc_wr2 = 0;
      alloc_rd1 = 0; alloc_rd2 = 0; wb_en1 = 0; wb_en2 = 0;
      wb_tag1 = 0; wb_tag2 = 0; wb_data1 = 0; wb_data2 = 0;
   endtask

   task automatic wait_empty(input int max, input string nm);
      int n = 0;
      while (count != 0 && n < max) begin
         step();
         n++;
      end
      chk(nm, 32'(count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      idle_in();
      rst = 1;
      alloc_en1 = 1;
      #2;
      chk("rst_rd_en1", 32'(rd_en1), 0);
      chk("rst_rd_en2", 32'(rd_en2), 0);
      chk("rst_rd1", 32'(rd1), 0);
      chk("rst_rd_data2", rd_data2, 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_ready", 32'(alloc_ready), 1);
      chk("rst_tag1", 32'(alloc_tag1), 0);
      chk("rst_tag2", 32'(alloc_tag2), 1);
      chk("rst_count", 32'(count), 0);
      alloc_en1 = 0;
      step(); step();
      rst = 0;
      step();
      chk("post_rst_count", 32'(count), 0);

      // a1 a2 r1 r2 w1 w2 | wb1 t1 d1 | wb2 t2 d2 | etag1 etag2 ecnt erden erd1 ed1
      tv[0]  = '{1,1,5'd3,5'd5,1,1, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd0,4'd1,5'd2,2'b00,5'd0,32'h0};
      tv[1]  = '{0,0,5'd0,5'd0,0,0, 1,4'd1,32'hB,  0,4'd0,32'h0,    4'd2,4'd2,5'd2,2'b00,5'd0,32'h0};
      tv[2]  = '{0,0,5'd0,5'd0,0,0, 1,4'd0,32'hA,  0,4'd0,32'h0,    4'd2,4'd2,5'd2,2'b11,5'd3,32'hA};
      tv[3]  = '{0,0,5'd0,5'd0,0,0, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd2,4'd2,5'd0,2'b00,5'd0,32'h0};
      tv[4]  = '{1,0,5'd7,5'd0,0,0, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd2,4'd3,5'd1,2'b00,5'd0,32'h0};
      tv[5]  = '{0,0,5'd0,5'd0,0,0, 0,4'd0,32'h0,  1,4'd2,32'h77,   4'd3,4'd3,5'd1,2'b00,5'd7,32'h77};
      tv[6]  = '{0,0,5'd0,5'd0,0,0, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd3,4'd3,5'd0,2'b00,5'd0,32'h0};
      tv[7]  = '{1,0,5'd9,5'd0,1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd3,4'd4,5'd1,2'b00,5'd0,32'h0};
      tv[8]  = '{0,0,5'd0,5'd0,0,0, 1,4'd3,32'h11, 1,4'd3,32'h22,   4'd4,4'd4,5'd1,2'b01,5'd9,32'h22};
      tv[9]  = '{0,0,5'd0,5'd0,0,0, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd4,4'd4,5'd0,2'b00,5'd0,32'h0};
      tv[10] = '{0,1,5'd0,5'd4,0,1, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd4,4'd4,5'd1,2'b00,5'd0,32'h0};
      tv[11] = '{0,0,5'd0,5'd0,0,0, 1,4'd4,32'h33, 1,4'd9,32'hDEAD, 4'd5,4'd5,5'd1,2'b01,5'd4,32'h33};
      tv[12] = '{0,0,5'd0,5'd0,0,0, 0,4'd0,32'h0,  0,4'd0,32'h0,    4'd5,4'd5,5'd0,2'b00,5'd0,32'h0};
      sb.push_back('{5'd3, 32'hA});
      sb.push_back('{5'd5, 32'hB});
      sb.push_back('{5'd9, 32'h22});
      sb.push_back('{5'd4, 32'h33});

      for (int i = 0; i < 13; i++) begin
         alloc_en1 = tv[i].a1; alloc_en2 = tv[i].a2;
         alloc_rd1 = tv[i].r1; alloc_rd2 = tv[i].r2;
         alloc_wr1 = tv[i].w1; alloc_wr2 = tv[i].w2;
         wb_en1 = tv[i].wb1; wb_tag1 = tv[i].t1; wb_data1 = tv[i].d1;
         wb_en2 = tv[i].wb2; wb_tag2 = tv[i].t2; wb_data2 = tv[i].d2;
         #1;
         chk($sformatf("v%0d_tag1", i), 32'(alloc_tag1), 32'(tv[i].etag1));
         chk($sformatf("v%0d_tag2", i), 32'(alloc_tag2), 32'(tv[i].etag2));
         @(posedge clk); #1;
         chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].ecnt));
         chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].ecnt == 0));
         chk($sformatf("v%0d_rden", i), 32'({rd_en2, rd_en1}), 32'(tv[i].erden));
         chk($sformatf("v%0d_rd1", i), 32'(rd1), 32'(tv[i].erd1));
         chk($sformatf("v%0d_rdata1", i), rd_data1, tv[i].ed1);
         chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 1);
      end
      idle_in();

      // Fill to capacity starting at tag 5, then hold allocation while blocked.
      for (int i = 0; i < 8; i++) begin
         alloc_en1 = 1; alloc_en2 = 1; alloc_wr1 = 1; alloc_wr2 = 1;
         alloc_rd1 = 5'(2*i); alloc_rd2 = 5'(2*i+1);
         sb.push_back('{5'(2*i),   32'h5000_0000 + 32'((5+2*i) % 16)});
         sb.push_back('{5'(2*i+1), 32'h5000_0000 + 32'((6+2*i) % 16)});
         #1;
         chk("fill_tag1", 32'(alloc_tag1), 32'((5+2*i) % 16));
         @(posedge clk); #1;
      end
      chk("fill_count", 32'(count), 16);
      chk("fill_full", 32'(full), 1);
      chk("fill_ready", 32'(alloc_ready), 0);
      step();
      chk("held_count", 32'(count), 16);
      chk("held_tag1", 32'(alloc_tag1), 5);
      wb_en1 = 1; wb_tag1 = 4'd5; wb_data1 = 32'h5000_0005;
      step();
      wb_en1 = 0;
      chk("blk_count16", 32'(count), 16);
      step();
      chk("one_cmt_count", 32'(count), 15);
      chk("one_cmt_ready", 32'(alloc_ready), 0);
      chk("one_cmt_full", 32'(full), 0);
      wb_en1 = 1; wb_tag1 = 4'd6; wb_data1 = 32'h5000_0006;
      step();
      wb_en1 = 0;
      step();
      chk("two_cmt_count", 32'(count), 14);
      chk("two_cmt_ready", 32'(alloc_ready), 1);
      alloc_en1 = 0; alloc_en2 = 0;
      #1;
      chk("two_cmt_tag1", 32'(alloc_tag1), 5);
      for (int j = 0; j < 7; j++) begin
         wb_en1 = 1; wb_tag1 = 4'((7+2*j) % 16); wb_data1 = 32'h5000_0000 + 32'((7+2*j) % 16);
         wb_en2 = 1; wb_tag2 = 4'((8+2*j) % 16); wb_data2 = 32'h5000_0000 + 32'((8+2*j) % 16);
         step();
      end
      idle_in();
      wait_empty(8, "fill_drain");

      // Continuous two-wide stream of 40 instructions, tags wrap through 15->0.
      for (int k = 0; k < 20; k++) begin
         alloc_en1 = 1; alloc_en2 = 1; alloc_wr1 = 1; alloc_wr2 = 1;
         alloc_rd1 = 5'((2*k) % 32); alloc_rd2 = 5'((2*k+1) % 32);
         sb.push_back('{5'((2*k) % 32),   32'hA000_0000 + 32'(2*k)});
         sb.push_back('{5'((2*k+1) % 32), 32'hA000_0000 + 32'(2*k+1)});
         wb_en1 = (k > 0); wb_en2 = (k > 0);
         wb_tag1 = 4'((5 + 2*(k-1)) % 16); wb_data1 = 32'hA000_0000 + 32'(2*k-2);
         wb_tag2 = 4'((6 + 2*(k-1)) % 16); wb_data2 = 32'hA000_0000 + 32'(2*k-1);
         #1;
         chk($sformatf("strm%0d_tag1", k), 32'(alloc_tag1), 32'((5+2*k) % 16));
         @(posedge clk); #1;
         chk($sformatf("strm%0d_count", k), 32'(count), (k == 0) ? 2 : 4);
      end
      idle_in();
      wb_en1 = 1; wb_tag1 = 4'd11; wb_data1 = 32'hA000_0000 + 32'd38;
      wb_en2 = 1; wb_tag2 = 4'd12; wb_data2 = 32'hA000_0000 + 32'd39;
      step();
      idle_in();
      wait_empty(6, "strm_drain");

      // Flush with 6 entries while a commit, allocation and writeback are all pending.
      for (int i = 0; i < 3; i++) begin
         alloc_en1 = 1; alloc_en2 = 1; alloc_wr1 = 1; alloc_wr2 = 1;
         alloc_rd1 = 5'd20; alloc_rd2 = 5'd21;
         step();
      end
      idle_in();
      chk("pre_flush_count", 32'(count), 6);
      wb_en1 = 1; wb_tag1 = 4'd13; wb_data1 = 32'h1234;
      step();
      flush = 1; alloc_en1 = 1; alloc_en2 = 1; alloc_wr1 = 1; alloc_wr2 = 1;
      wb_en1 = 1; wb_tag1 = 4'd14; wb_data1 = 32'h5678;
      #1;
      chk("flush_rd_en1", 32'(rd_en1), 0);
      chk("flush_rd_en2", 32'(rd_en2), 0);
      @(posedge clk); #1;
      idle_in();
      #1;
      chk("flush_count", 32'(count), 0);
      chk("flush_empty", 32'(empty), 1);
      chk("flush_tag1", 32'(alloc_tag1), 0);
      chk("flush_after_rden", 32'(rd_en1), 0);
      step();
      chk("flush_count2", 32'(count), 0);

      // Asynchronous reset while writebacks are in flight.
      alloc_en1 = 1; alloc_en2 = 1; alloc_wr1 = 1; alloc_wr2 = 1;
      alloc_rd1 = 5'd1; alloc_rd2 = 5'd2;
      step();
      idle_in();
      wb_en1 = 1; wb_tag1 = 4'd0; wb_data1 = 32'hAA;
      wb_en2 = 1; wb_tag2 = 4'd1; wb_data2 = 32'hBB;
      #2;
      rst = 1;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_empty", 32'(empty), 1);
      chk("arst_rd_en1", 32'(rd_en1), 0);
      chk("arst_rd1", 32'(rd1), 0);
      idle_in();
      step(); step();
      rst = 0;
      step();
      chk("arst_post_count", 32'(count), 0);
      chk("arst_post_rden", 32'({rd_en2, rd_en1}), 0);
      chk("arst_post_tag1", 32'(alloc_tag1), 0);

      chk("sb_leftover", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
